// File: rtl/spinner_pkg.sv
// spinner_pkg: shared types and helpers for the spinner emulator.
//   spin_mode_e  - input source select (buttons, analog, mouse, off)
//   sat_add12    - signed 12-bit add saturating at +/-2047
//   clamp_delta  - limits a signed step to +/-(2^(angle_w-1)-1)
package spinner_pkg;

   typedef enum logic [1:0] {
      SPIN_BUTTONS = 2'd0,
      SPIN_ANALOG  = 2'd1,
      SPIN_MOUSE   = 2'd2,
      SPIN_OFF     = 2'd3
   } spin_mode_e;

   // Wide enough for any step: mouse (12 bit) or buttons up to 2^15-1.
   localparam int unsigned DELTA_W = 18;
   localparam int unsigned MACC_W  = 12;

   function automatic logic signed [MACC_W-1:0] sat_add12(input logic signed [MACC_W-1:0] a,
                                                          input logic signed [MACC_W-1:0] b);
      logic signed [MACC_W:0] s;
      s = {a[MACC_W-1], a} + {b[MACC_W-1], b};
      if (s > 13'sd2047) begin
         return 12'sd2047;
      end else if (s < -13'sd2047) begin
         return -12'sd2047;
      end
      return s[MACC_W-1:0];
   endfunction

   // A step of half the circle or more would be ambiguous in direction.
   function automatic logic signed [DELTA_W-1:0] clamp_delta(input logic signed [DELTA_W-1:0] d,
                                                             input int unsigned angle_w);
      logic signed [DELTA_W-1:0] lim;
      lim = DELTA_W'((1 << (angle_w - 1)) - 1);
      if (d > lim) begin
         return lim;
      end else if (d < -lim) begin
         return -lim;
      end
      return d;
   endfunction

endpackage

// File: rtl/spinner_gen_channel.sv
// spinner_channel: one spinner channel (position, button speed, delta select, clamp).
//   clock_40, reset          - clock and synchronous active-high reset
//   tick                     - one-cycle frame strobe
//   mode, mode_chg           - current mode and "mode changed this cycle" flag
//   btn_left/right/acc       - button inputs for this channel
//   analog_x                 - signed stick value
//   mouse_delta              - pre-shifted mouse step (zero for channels other than 0)
//   pos                      - wrapping angle output
//   moving                   - last applied delta was nonzero
module spinner_channel #(
   parameter int unsigned ANGLE_W      = 4,
   parameter int unsigned ACC_MAX      = 7,
   parameter int unsigned ANALOG_SHIFT = 4,
   parameter int unsigned DEADZONE     = 8
) (
   input  logic               clock_40,
   input  logic               reset,
   input  logic               tick,
   input  logic [1:0]         mode,
   input  logic               mode_chg,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic               btn_acc,
   input  logic [7:0]         analog_x,
   input  logic [17:0]        mouse_delta,
   output logic [ANGLE_W-1:0] pos,
   output logic               moving
);
   import spinner_pkg::*;

   localparam int unsigned SPD_W = $clog2(ACC_MAX + 1);

   spin_mode_e mode_e;
   logic [ANGLE_W-1:0] pos_q, pos_d;
   logic [SPD_W-1:0] spd_q, spd_d, spd_base, spd_new;
   logic moving_q, moving_d;
   logic signed [DELTA_W-1:0] delta_raw, delta;
   logic signed [7:0] ax, ax_sh;
   logic [7:0] mag;

   assign mode_e = spin_mode_e'(mode);

   // -128 has no positive twin; fold it onto -127.
   assign ax    = (analog_x == 8'h80) ? 8'sh81 : $signed(analog_x);
   assign mag   = ax[7] ? 8'(-ax) : 8'(ax);
   assign ax_sh = ax >>> ANALOG_SHIFT;

   always_comb begin
      // A mode change restarts acceleration even on a coincident tick.
      spd_base  = mode_chg ? '0 : spd_q;
      spd_d     = spd_base;
      spd_new   = '0;
      delta_raw = '0;
      if (tick) begin
         spd_d = '0;
         case (mode_e)
            SPIN_BUTTONS: begin
               if (btn_left ^ btn_right) begin
                  if (!btn_acc) begin
                     spd_new = SPD_W'(1);
                  end else if (spd_base >= SPD_W'(ACC_MAX)) begin
                     spd_new = SPD_W'(ACC_MAX);
                  end else begin
                     spd_new = spd_base + 1'b1;
                  end
                  spd_d     = spd_new;
                  delta_raw = btn_right ? DELTA_W'(spd_new) : -DELTA_W'(spd_new);
               end
            end
            SPIN_ANALOG: begin
               if (int'(mag) >= int'(DEADZONE)) begin
                  delta_raw = {{(DELTA_W-8){ax_sh[7]}}, ax_sh};
               end
            end
            SPIN_MOUSE:  delta_raw = mouse_delta;
            default:     delta_raw = '0;
         endcase
      end
   end

   assign delta = clamp_delta(delta_raw, ANGLE_W);

   always_comb begin
      pos_d    = pos_q;
      moving_d = moving_q;
      if (tick) begin
         pos_d    = pos_q + delta[ANGLE_W-1:0];
         moving_d = (delta != '0);
      end
   end

   always_ff @(posedge clock_40) begin
      if (reset) begin
         pos_q    <= '0;
         spd_q    <= '0;
         moving_q <= 1'b0;
      end else begin
         pos_q    <= pos_d;
         spd_q    <= spd_d;
         moving_q <= moving_d;
      end
   end

   assign pos    = pos_q;
   assign moving = moving_q;

endmodule

// File: rtl/spinner_gen.sv
// spinner_gen: rotary-control emulator, one position update per vsync rising edge.
//   clock_40, reset     - 40 MHz clock, synchronous active-high reset
//   vsync               - frame reference
//   mode                - 0 buttons, 1 analog, 2 mouse, 3 off
//   btn_left/right/acc  - per-channel buttons
//   analog_x            - per-channel signed stick X, 8 bits each
//   mouse_dx/strobe     - signed mouse delta with one-cycle valid (channel 0)
//   spin_angle          - per-channel wrapping angle
//   spin_moving         - per-channel motion flag
module spinner_gen #(
   parameter int unsigned CHANNELS     = 2,
   parameter int unsigned ANGLE_W      = 4,
   parameter int unsigned ACC_MAX      = 7,
   parameter int unsigned ANALOG_SHIFT = 4,
   parameter int unsigned DEADZONE     = 8,
   parameter int unsigned MOUSE_SHIFT  = 1
) (
   input  logic                        clock_40,
   input  logic                        reset,
   input  logic                        vsync,
   input  logic [1:0]                  mode,
   input  logic [CHANNELS-1:0]         btn_left,
   input  logic [CHANNELS-1:0]         btn_right,
   input  logic [CHANNELS-1:0]         btn_acc,
   input  logic [8*CHANNELS-1:0]       analog_x,
   input  logic [8:0]                  mouse_dx,
   input  logic                        mouse_strobe,
   output logic [ANGLE_W*CHANNELS-1:0] spin_angle,
   output logic [CHANNELS-1:0]         spin_moving
);
   import spinner_pkg::*;

   logic vsync_q, vsync_qq, tick_q;
   logic [1:0] mode_q;
   logic mode_chg;
   logic signed [MACC_W-1:0] macc_q, macc_d, macc_base, delta0;
   logic signed [DELTA_W-1:0] mouse_delta;

   assign mode_chg  = (mode != mode_q);
   assign macc_base = mode_chg ? '0 : macc_q;
   assign delta0    = macc_base >>> MOUSE_SHIFT;
   assign mouse_delta = {{(DELTA_W-MACC_W){delta0[MACC_W-1]}}, delta0};

   // The remainder below the shift is carried to the next frame; a strobe
   // landing on the tick is added after the remainder is taken.
   always_comb begin
      macc_d = '0;
      if (spin_mode_e'(mode) == SPIN_MOUSE) begin
         macc_d = macc_base;
         if (tick_q) begin
            macc_d = macc_base - (delta0 <<< MOUSE_SHIFT);
         end
         if (mouse_strobe) begin
            macc_d = sat_add12(macc_d, {{(MACC_W-9){mouse_dx[8]}}, mouse_dx});
         end
      end
   end

   always_ff @(posedge clock_40) begin
      if (reset) begin
         vsync_q  <= 1'b0;
         vsync_qq <= 1'b0;
         tick_q   <= 1'b0;
         mode_q   <= 2'd0;
         macc_q   <= '0;
      end else begin
         vsync_q  <= vsync;
         vsync_qq <= vsync_q;
         tick_q   <= vsync_q & ~vsync_qq;
         mode_q   <= mode;
         macc_q   <= macc_d;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [DELTA_W-1:0] ch_mouse;
      assign ch_mouse = (i == 0) ? mouse_delta : '0;

      spinner_channel #(
         .ANGLE_W      (ANGLE_W),
         .ACC_MAX      (ACC_MAX),
         .ANALOG_SHIFT (ANALOG_SHIFT),
         .DEADZONE     (DEADZONE)
      ) u_ch (
         .clock_40    (clock_40),
         .reset       (reset),
         .tick        (tick_q),
         .mode        (mode),
         .mode_chg    (mode_chg),
         .btn_left    (btn_left[i]),
         .btn_right   (btn_right[i]),
         .btn_acc     (btn_acc[i]),
         .analog_x    (analog_x[8*i +: 8]),
         .mouse_delta (ch_mouse),
         .pos         (spin_angle[ANGLE_W*i +: ANGLE_W]),
         .moving      (spin_moving[i])
      );
   end

endmodule

// File: tb/tb_spinner_gen.sv
// tb_spinner_gen: self-checking bench for spinner_gen with a frame-level reference model.
// Two instances: default parameters (2 channels, 4-bit angle) and a 1-channel 8-bit,
// ACC_MAX=127 instance sharing channel 0 stimulus.
module tb_spinner_gen;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic vsync = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [1:0] btn_left = '0, btn_right = '0, btn_acc = '0;
   logic [15:0] analog_x = '0;
   logic [8:0] mouse_dx = '0;
   logic mouse_strobe = 1'b0;
   logic [7:0] spin_angle;
   logic [1:0] spin_moving;
   logic [7:0] angle8;
   logic moving8;

   int n_pass = 0, n_total = 0;

   // Model state: index 0/1 = main DUT channels 0/1, index 2 = 8-bit DUT channel 0.
   int mpos[3], mspd[3];
   bit mmov[3];
   int macc;
   int mw[3]   = '{4, 4, 8};
   int mmax[3] = '{7, 7, 127};
   int mch[3]  = '{0, 1, 0};

   always #5 clk = ~clk;

   spinner_gen dut (
      .clock_40     (clk),
      .reset        (reset),
      .vsync        (vsync),
      .mode         (mode),
      .btn_left     (btn_left),
      .btn_right    (btn_right),
      .btn_acc      (btn_acc),
      .analog_x     (analog_x),
      .mouse_dx     (mouse_dx),
      .mouse_strobe (mouse_strobe),
      .spin_angle   (spin_angle),
      .spin_moving  (spin_moving)
   );

   spinner_gen #(
      .CHANNELS (1),
      .ANGLE_W  (8),
      .ACC_MAX  (127)
   ) dut8 (
      .clock_40     (clk),
      .reset        (reset),
      .vsync        (vsync),
      .mode         (mode),
      .btn_left     (btn_left[0]),
      .btn_right    (btn_right[0]),
      .btn_acc      (btn_acc[0]),
      .analog_x     (analog_x[7:0]),
      .mouse_dx     (mouse_dx),
      .mouse_strobe (mouse_strobe),
      .spin_angle   (angle8),
      .spin_moving  (moving8)
   );

   function automatic int got_angle(input int k);
      if (k == 0) return int'(spin_angle[3:0]);
      if (k == 1) return int'(spin_angle[7:4]);
      return int'(angle8);
   endfunction

   function automatic int got_moving(input int k);
      if (k == 2) return int'(moving8);
      return int'(spin_moving[k]);
   endfunction

   function automatic int fdiv(input int a, input int b);
      return (a >= 0) ? a / b : -((-a + b - 1) / b);
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         mpos[k] = 0; mspd[k] = 0; mmov[k] = 0;
      end
      macc = 0;
   endfunction

   function automatic void model_strobe(input logic [8:0] dx);
      if (mode == 2'd2) begin
         macc = macc + int'($signed(dx));
         if (macc > 2047) macc = 2047;
         if (macc < -2047) macc = -2047;
      end
   endfunction

   // One frame worth of motion from the rules, applied to every modelled channel.
   function automatic void model_tick();
      int d0, d, v, lim, m, c;
      d0 = fdiv(macc, 2);
      for (int k = 0; k < 3; k++) begin
         c = mch[k];
         d = 0;
         case (mode)
            2'd0: begin
               if (btn_left[c] != btn_right[c]) begin
                  mspd[k] = btn_acc[c] ? ((mspd[k] + 1 > mmax[k]) ? mmax[k] : mspd[k] + 1) : 1;
                  d = btn_right[c] ? mspd[k] : -mspd[k];
               end else begin
                  mspd[k] = 0;
               end
            end
            2'd1: begin
               v = int'($signed(analog_x[c*8 +: 8]));
               if (v == -128) v = -127;
               d = ((v < 0 ? -v : v) < 8) ? 0 : fdiv(v, 16);
               mspd[k] = 0;
            end
            2'd2: begin
               d = (c == 0) ? d0 : 0;
               mspd[k] = 0;
            end
            default: mspd[k] = 0;
         endcase
         lim = (1 << (mw[k] - 1)) - 1;
         if (d > lim) d = lim;
         if (d < -lim) d = -lim;
         m = 1 << mw[k];
         mpos[k] = ((mpos[k] + d) % m + m) % m;
         mmov[k] = (d != 0);
      end
      if (mode == 2'd2) macc = macc - 2 * d0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; vsync = 1'b0; mouse_strobe = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic set_mode(input logic [1:0] m);
      @(negedge clk);
      if (m != mode) begin
         for (int k = 0; k < 3; k++) mspd[k] = 0;
         macc = 0;
      end
      mode = m;
      @(negedge clk);
   endtask

   task automatic strobe(input logic [8:0] dx);
      @(negedge clk);
      mouse_strobe = 1'b1; mouse_dx = dx;
      @(negedge clk);
      mouse_strobe = 1'b0;
      model_strobe(dx);
   endtask

   // vsync rises before edge N; tick in the cycle after N+1; update at N+2.
   task automatic frame(input bit do_strobe, input logic [8:0] dx);
      @(negedge clk) vsync = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      if (do_strobe) begin
         mouse_strobe = 1'b1; mouse_dx = dx;
      end
      @(posedge clk);
      @(negedge clk);
      mouse_strobe = 1'b0; vsync = 1'b0;
      model_tick();
      if (do_strobe) model_strobe(dx);
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if (got_angle(k) !== 0) $display("FAIL reset_angle[%0d]: got %0d want 0", k, got_angle(k));
         else n_pass++;
         n_total++;
         if (got_moving(k) !== 0) $display("FAIL reset_moving[%0d]: got %0d want 0", k, got_moving(k));
         else n_pass++;
      end
   endtask

   task automatic test_buttons_acc();
      int exp_a[6] = '{1, 3, 6, 10, 15, 5};
      do_reset();
      set_mode(2'd0);
      btn_left = 2'b00; btn_right = 2'b01; btn_acc = 2'b01;
      for (int f = 0; f < 6; f++) begin
         frame(0, '0);
         n_total++;
         if (got_angle(0) !== exp_a[f])
            $display("FAIL btn_acc_angle f%0d: got %0d want %0d", f, got_angle(0), exp_a[f]);
         else n_pass++;
         for (int k = 1; k < 3; k++) begin
            n_total++;
            if (got_angle(k) !== mpos[k])
               $display("FAIL btn_acc_model[%0d] f%0d: got %0d want %0d", k, f, got_angle(k), mpos[k]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_both_and_left();
      int exp_l[2] = '{15, 14};
      do_reset();
      set_mode(2'd0);
      btn_left = 2'b01; btn_right = 2'b01; btn_acc = 2'b00;
      for (int f = 0; f < 3; f++) begin
         frame(0, '0);
         n_total++;
         if (got_angle(0) !== 0 || got_moving(0) !== 0)
            $display("FAIL both_held f%0d: got angle %0d moving %0d want 0 0", f, got_angle(0),
                     got_moving(0));
         else n_pass++;
      end
      btn_right = 2'b00;
      for (int f = 0; f < 2; f++) begin
         frame(0, '0);
         n_total++;
         if (got_angle(0) !== exp_l[f] || got_moving(0) !== 1)
            $display("FAIL left_noacc f%0d: got %0d want %0d", f, got_angle(0), exp_l[f]);
         else n_pass++;
      end
      btn_left = 2'b00;
   endtask

   task automatic test_analog();
      do_reset();
      set_mode(2'd1);
      analog_x = {8'd100, 8'hF9};  // ch1 +100, ch0 -7
      frame(0, '0);
      n_total++;
      if (got_angle(1) !== 6) $display("FAIL analog_pos: got %0d want 6", got_angle(1));
      else n_pass++;
      n_total++;
      if (got_angle(0) !== 0 || got_moving(0) !== 0)
         $display("FAIL analog_deadzone: got %0d mov %0d want 0 0", got_angle(0), got_moving(0));
      else n_pass++;
      analog_x = {8'h80, 8'h80};
      frame(0, '0);
      n_total++;
      if (got_angle(1) !== 15) $display("FAIL analog_m128: got %0d want 15", got_angle(1));
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if (got_angle(k) !== mpos[k] || got_moving(k) !== int'(mmov[k]))
            $display("FAIL analog_model[%0d]: got %0d want %0d", k, got_angle(k), mpos[k]);
         else n_pass++;
      end
      analog_x = '0;
   endtask

   task automatic test_mouse();
      do_reset();
      set_mode(2'd2);
      strobe(9'd5);
      strobe(9'd4);
      frame(0, '0);
      n_total++;
      if (got_angle(0) !== 4 || got_angle(2) !== 4)
         $display("FAIL mouse_delta: got %0d/%0d want 4/4", got_angle(0), got_angle(2));
      else n_pass++;
      frame(1, 9'd3);
      n_total++;
      if (got_angle(0) !== 4 || got_moving(0) !== 0)
         $display("FAIL mouse_coinc: got %0d mov %0d want 4 0", got_angle(0), got_moving(0));
      else n_pass++;
      frame(0, '0);
      n_total++;
      if (got_angle(0) !== 6 || got_angle(1) !== 0)
         $display("FAIL mouse_remainder: got %0d ch1 %0d want 6 0", got_angle(0), got_angle(1));
      else n_pass++;
   endtask

   task automatic test_timing();
      do_reset();
      set_mode(2'd0);
      btn_right = 2'b01; btn_acc = 2'b00;
      @(negedge clk) vsync = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if (got_angle(0) !== 0) $display("FAIL timing_early: got %0d want 0", got_angle(0));
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if (got_angle(0) !== 1 || got_moving(0) !== 1)
         $display("FAIL timing_update: got %0d mov %0d want 1 1", got_angle(0), got_moving(0));
      else n_pass++;
      model_tick();
      repeat (5) @(negedge clk);
      n_total++;
      if (got_angle(0) !== 1) $display("FAIL vsync_held: got %0d want 1", got_angle(0));
      else n_pass++;
      vsync = 1'b0;
      repeat (2) @(negedge clk);
      btn_right = 2'b00;
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_mode(2'd0);
      btn_right = 2'b11;
      frame(0, '0);
      @(negedge clk) vsync = 1'b1;
      @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      @(negedge clk) vsync = 1'b0;
      @(negedge clk) reset = 1'b0;
      btn_right = 2'b00;
      model_reset();
      repeat (4) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if (got_angle(k) !== 0 || got_moving(k) !== 0)
            $display("FAIL reset_mid[%0d]: got %0d mov %0d want 0 0", k, got_angle(k), got_moving(k));
         else n_pass++;
      end
   endtask

   task automatic test_mode_switch();
      do_reset();
      set_mode(2'd2);
      strobe(9'd9);
      frame(0, '0);   // delta 4, remainder 1
      strobe(9'd8);   // macc 9
      set_mode(2'd0);
      n_total++;
      if (got_angle(0) !== 4) $display("FAIL mode_sw_hold: got %0d want 4", got_angle(0));
      else n_pass++;
      set_mode(2'd2);
      frame(0, '0);
      n_total++;
      if (got_angle(0) !== 4 || got_moving(0) !== 0)
         $display("FAIL mode_sw_macc_clr: got %0d mov %0d want 4 0", got_angle(0), got_moving(0));
      else n_pass++;
   endtask

   task automatic test_accel8();
      int prev, step;
      do_reset();
      set_mode(2'd0);
      btn_right = 2'b01; btn_acc = 2'b01;
      for (int f = 0; f < 40; f++) begin
         prev = got_angle(2);
         frame(0, '0);
         step = (got_angle(2) - prev + 256) % 256;
         n_total++;
         if (got_angle(2) !== mpos[2] || step > 127)
            $display("FAIL accel8 f%0d: got %0d want %0d step %0d", f, got_angle(2), mpos[2], step);
         else n_pass++;
      end
      n_total++;
      if (got_angle(0) !== mpos[0])
         $display("FAIL accel4_clamp: got %0d want %0d", got_angle(0), mpos[0]);
      else n_pass++;
      btn_right = 2'b00; btn_acc = 2'b00;
   endtask

   task automatic test_random();
      logic [8:0] dx;
      do_reset();
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 3) == 0) set_mode(2'($urandom_range(0, 3)));
         btn_left  = 2'($urandom);
         btn_right = 2'($urandom);
         btn_acc   = 2'($urandom);
         analog_x  = 16'($urandom);
         if (mode == 2'd2) begin
            for (int s = 0; s < int'($urandom_range(0, 3)); s++) strobe(9'($urandom));
         end
         dx = 9'($urandom);
         frame((mode == 2'd2) && ($urandom_range(0, 1) == 1), dx);
         for (int k = 0; k < 3; k++) begin
            n_total++;
            if (got_angle(k) !== mpos[k] || got_moving(k) !== int'(mmov[k]))
               $display("FAIL random f%0d ch%0d: got %0d/%0d want %0d/%0d", f, k, got_angle(k),
                        got_moving(k), mpos[k], int'(mmov[k]));
            else n_pass++;
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_buttons_acc();
      test_both_and_left();
      test_analog();
      test_mouse();
      test_timing();
      test_reset_mid();
      test_mode_switch();
      test_accel8();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
